// File: rtl/led_serial_tx.sv
// Serialises a WIDTH-bit LED pattern MSB-first onto sdata/sclk, then pulses latch
// so the external capture chain transfers the frame to its outputs.
module led_serial_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [DIV_W-1:0] div, div_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic             sclk_d, latch_d, busy_d, done_d;

  // Zero fill drains the register to 0 by the end of SHIFT, so its MSB is
  // already the required idle/latch level of sdata.
  assign sdata = shreg[WIDTH-1];

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      div     <= div_d;
      bit_cnt <= bit_cnt_d;
      sclk    <= sclk_d;
      latch   <= latch_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; sclk itself marks which half of the bit period is running.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    div_d     = div;
    bit_cnt_d = bit_cnt;
    sclk_d    = sclk;
    latch_d   = latch;
    busy_d    = busy;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          shreg_d   = pattern;
          div_d     = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (div == DIV_LAST) begin
          div_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt + CNT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              latch_d = 1'b1;
              state_d = LATCH;
            end
          end
        end else begin
          div_d = div + DIV_W'(1);
        end
      end

      LATCH: begin
        if (div == DIV_LAST) begin
          div_d   = '0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
